ptmch_trg_multi: RTL and testbench
==================================

// Module: ptmch_trg_multi
// PURPOSE
//  Parametrised successor of the 2-channel SPI trigger block. Receives 32-bit command frames
//  over a 3-wire SPI slave, oversampled in the CLK160M domain. Drives NCH independent trigger
//  outputs; each has programmable delay, pulse width, period and burst count. Sits directly
//  under ptmch_top, replacing the fixed-pulse trigger instance.
// PARAMETERS
//  NCH    2   number of trigger channels (1..15)
//  CNT_W  16  width of delay/width/period/count registers (<=24)
// PORTS
//  CLK160M   in   1      sole clock, 160 MHz
//  RESET     in   1      synchronous, active-high reset
//  SPI_CS    in   1      SPI chip select, active-low, asynchronous to CLK160M
//  SPI_CLK   in   1      SPI clock, mode 0, max CLK160M/8, asynchronous
//  SPI_MOSI  in   1      SPI data, MSB first
//  TRG_PLS   out  NCH    trigger pulses, registered
//  BUSY      out  NCH    channel not IDLE
//  FRM_ERR   out  1      1-cycle pulse: frame rejected
// BEHAVIOUR
//  - Reset: TRG_PLS=0, BUSY=0, FRM_ERR=0, all FSMs IDLE, shift reg/bit count cleared.
//    Config regs per channel reset to DLY=0, WID=1, PER=2, CNT=1.
//  - SPI_CS, SPI_CLK, SPI_MOSI each pass through a 2-FF synchroniser. MOSI is sampled on the
//    synced SPI_CLK rising edge while CS is low. Bit count saturates at 33.
//  - Frame: [31:28] cmd, [27:24] ch, [CNT_W-1:0] data. Data bits above CNT_W are ignored.
//  - Frame commits on the synced CS rising edge (cycle C) only when exactly 32 bits were
//    received. Otherwise FRM_ERR=1 at C+1 and the frame is dropped.
//    CS falling mid-frame restarts the count.
//  - Commands:
//      0x1 DLY, 0x2 WID, 0x3 PER, 0x4 CNT write the config reg.
//      0x8 FIRE arms a channel; 0xF ABORT stops it.
//      ch=0xF broadcasts FIRE/ABORT only.
//      Unknown cmd, ch>=NCH (non-broadcast), or broadcast config write -> FRM_ERR at C+1,
//      no effect.
//  - Config writes are always accepted. They are latched into working regs only on FIRE,
//    so a running burst is unaffected.
//  - Channel FSM states: IDLE -> DLY -> HIGH -> LOW -> HIGH ... -> IDLE
//      IDLE: on FIRE at C, latch config. WID==0 -> remain IDLE, no pulse, no error.
//      DLY:  TRG_PLS first rises at cycle C+2+DLY (DLY=0 gives C+2).
//      HIGH: lasts exactly WID cycles.
//      LOW:  lasts max(PER-WID,1) cycles, i.e. effective rising-edge spacing is
//            max(PER,WID+1).
//      CNT pulses are emitted; CNT=0 is treated as 1. After the last HIGH -> IDLE.
//  - FIRE to a busy channel: ignored, FRM_ERR pulsed. A broadcast FIRE arms only idle
//    channels, with no error.
//  - ABORT at C: TRG_PLS=0 and BUSY=0 from C+1, FSM IDLE. ABORT on an idle channel is a no-op.
//  - BUSY=1 from C+1 of an accepted FIRE until the cycle after the last HIGH ends.
//  - All counters are CNT_W wide and load-then-decrement; no wrap-around.
//    Max DLY/WID = 2^CNT_W-1.
//  - RESET asserted mid-frame or mid-burst: immediate return to reset state on the next edge.
// STRUCTURE
//  - ptmch_pkg: typedef enum logic[3:0] cmd_e {CMD_DLY=1, CMD_WID=2, CMD_PER=3, CMD_CNT=4,
//    CMD_FIRE=8, CMD_ABORT=15}; CH_BCAST=4'hF; FRAME_W=32; ch_state_e.
//  - Sub-module ptmch_spi_rx: synchronisers, shift register, bit count, frame-valid/length-error
//    strobes.
//  - Top level: decode, config regs, and a generate loop of NCH channel FSMs.
// TESTING
//  1 Reset, then DLY=3/WID=4/CNT=1 to ch0, FIRE ch0 -> TRG_PLS[0] high at C+5..C+8,
//    BUSY[0] C+1..C+9.
//  2 ch1 WID=2, PER=5, CNT=3, FIRE -> three 2-cycle pulses, rising edges 5 cycles apart,
//    then IDLE.
//  3 31-bit and 33-bit frames -> FRM_ERR single pulse each, no TRG_PLS, config unchanged.
//  4 FIRE ch0 (CNT=100), WID write mid-burst, ABORT after 10 pulses -> burst width unchanged,
//    TRG_PLS=0 at C+1; next FIRE uses new WID.
//  5 Broadcast FIRE with ch0 busy, ch1 idle -> ch1 starts, ch0 unaffected, FRM_ERR=0;
//    cmd 0x5 -> FRM_ERR.
//  6 Assert RESET mid-frame and mid-pulse -> outputs 0 next cycle; following full frame works.

Source files
------------

// File: rtl/ptmch_pkg.sv
// Shared constants and types for the multi-channel SPI trigger block.
package ptmch_pkg;

  localparam int         FRAME_W  = 32;
  localparam logic [3:0] CH_BCAST = 4'hF;

  typedef enum logic [3:0] {
    CMD_DLY   = 4'h1,
    CMD_WID   = 4'h2,
    CMD_PER   = 4'h3,
    CMD_CNT   = 4'h4,
    CMD_FIRE  = 4'h8,
    CMD_ABORT = 4'hF
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DLY  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } ch_state_e;

endpackage

// File: rtl/ptmch_spi_rx.sv
// 3-wire SPI slave, mode 0, oversampled by the system clock. Emits a one-cycle
// frame-valid or length-error strobe on the synchronised CS rising edge.
module ptmch_spi_rx
  import ptmch_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               spi_cs_i,
  input  logic               spi_clk_i,
  input  logic               spi_mosi_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic               frm_vld_o,
  output logic               len_err_o
);

  localparam logic [5:0] BCNT_SAT = 6'd33;
  localparam logic [5:0] BCNT_FRM = 6'd32;

  logic [1:0]         cs_sync_q, sck_sync_q, mosi_sync_q;
  logic               cs_prev_q, sck_prev_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [5:0]         bcnt_q;
  logic               cs_s, sck_s, mosi_s, cs_rise, cs_fall, sck_rise;

  assign cs_s     = cs_sync_q[1];
  assign sck_s    = sck_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign sck_rise = sck_s & ~sck_prev_q;

  assign frame_o   = shreg_q;
  assign frm_vld_o = cs_rise & (bcnt_q == BCNT_FRM);
  assign len_err_o = cs_rise & (bcnt_q != BCNT_FRM);

  // Synchronisers, edge history, shift register and saturating bit count.
  // CS syncs reset to the idle (high) level so leaving reset never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_sync_q   <= 2'b11;
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
      shreg_q     <= '0;
      bcnt_q      <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_cs_i};
      sck_sync_q  <= {sck_sync_q[0], spi_clk_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
      cs_prev_q   <= cs_s;
      sck_prev_q  <= sck_s;
      if (cs_fall) begin
        bcnt_q <= '0;
      end else if (!cs_s && sck_rise) begin
        shreg_q <= {shreg_q[FRAME_W-2:0], mosi_s};
        if (bcnt_q != BCNT_SAT) bcnt_q <= bcnt_q + 6'd1;
      end
    end
  end

endmodule

// File: rtl/ptmch_trg_multi.sv
// NCH-channel programmable trigger generator commanded over SPI. Decodes
// committed frames, holds per-channel config, runs one pulse FSM per channel.
module ptmch_trg_multi
  import ptmch_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int CNT_W = 16
) (
  input  logic           CLK160M,
  input  logic           RESET,
  input  logic           SPI_CS,
  input  logic           SPI_CLK,
  input  logic           SPI_MOSI,
  output logic [NCH-1:0] TRG_PLS,
  output logic [NCH-1:0] BUSY,
  output logic           FRM_ERR
);

  localparam logic [3:0]       NCH_L = 4'(NCH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [FRAME_W-1:0] frame;
  logic               frm_vld, len_err;
  logic [3:0]         cmd, ch;
  logic [CNT_W-1:0]   data;
  logic               is_cfg, is_fire, is_abort, is_bc, ch_ok, busy_sel;
  logic               err_d, err_q;

  ptmch_spi_rx u_rx (
    .clk_i      (CLK160M),
    .rst_i      (RESET),
    .spi_cs_i   (SPI_CS),
    .spi_clk_i  (SPI_CLK),
    .spi_mosi_i (SPI_MOSI),
    .frame_o    (frame),
    .frm_vld_o  (frm_vld),
    .len_err_o  (len_err)
  );

  assign cmd      = frame[31:28];
  assign ch       = frame[27:24];
  assign data     = frame[CNT_W-1:0];
  assign is_cfg   = cmd inside {CMD_DLY, CMD_WID, CMD_PER, CMD_CNT};
  assign is_fire  = (cmd == CMD_FIRE);
  assign is_abort = (cmd == CMD_ABORT);
  assign is_bc    = (ch == CH_BCAST);
  assign ch_ok    = (ch < NCH_L);
  assign FRM_ERR  = err_q;

  if (CNT_W < 24) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^frame[23:CNT_W];
  end

  // Frame rejection: bad length, unknown cmd, bad channel, broadcast config,
  // or a directed FIRE to a channel that is still running.
  always_comb begin
    busy_sel = 1'b0;
    for (int k = 0; k < NCH; k++) if (ch == 4'(k)) busy_sel = BUSY[k];
    err_d = len_err;
    if (frm_vld) begin
      if (!(is_cfg || is_fire || is_abort))     err_d = 1'b1;
      else if (!is_bc && !ch_ok)                err_d = 1'b1;
      else if (is_cfg && is_bc)                 err_d = 1'b1;
      else if (is_fire && !is_bc && busy_sel)   err_d = 1'b1;
    end
  end

  // Error strobe appears the cycle after commit.
  always_ff @(posedge CLK160M) begin
    if (RESET) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_e        st_q, st_d;
    logic [CNT_W-1:0] dly_q, wid_q, per_q, cnt_q;
    logic [CNT_W-1:0] ctr_q, ctr_d, rem_q, rem_d;
    logic [CNT_W-1:0] wid_w_q, wid_w_d, low_w_q, low_w_d;
    logic             pls_q, cfg_wr, fire, abort;

    assign cfg_wr     = frm_vld & is_cfg & (ch == 4'(i));
    assign fire       = frm_vld & is_fire & (is_bc | (ch == 4'(i)));
    assign abort      = frm_vld & is_abort & (is_bc | (ch == 4'(i)));
    assign TRG_PLS[i] = pls_q;
    assign BUSY[i]    = (st_q != ST_IDLE);

    // Programmed config; only copied into the working regs on FIRE.
    always_ff @(posedge CLK160M) begin
      if (RESET) begin
        dly_q <= '0;
        wid_q <= ONE;
        per_q <= CNT_W'(2);
        cnt_q <= ONE;
      end else if (cfg_wr) begin
        case (cmd)
          CMD_DLY: dly_q <= data;
          CMD_WID: wid_q <= data;
          CMD_PER: per_q <= data;
          CMD_CNT: cnt_q <= data;
          default: ;
        endcase
      end
    end

    // Pulse sequencer. One shared down-counter times DLY/HIGH/LOW; rem counts
    // pulses left, and rem==0 in LOW marks the one-cycle tail after the last pulse.
    always_comb begin
      st_d    = st_q;
      ctr_d   = ctr_q;
      rem_d   = rem_q;
      wid_w_d = wid_w_q;
      low_w_d = low_w_q;
      case (st_q)
        ST_IDLE: if (fire && wid_q != '0) begin
          st_d    = ST_DLY;
          ctr_d   = dly_q;
          wid_w_d = wid_q;
          low_w_d = (per_q > wid_q) ? per_q - wid_q : ONE;
          rem_d   = (cnt_q == '0) ? ONE : cnt_q;
        end
        ST_DLY: if (ctr_q == '0) begin
          st_d  = ST_HIGH;
          ctr_d = wid_w_q - ONE;
        end else begin
          ctr_d = ctr_q - ONE;
        end
        ST_HIGH: if (ctr_q == '0) begin
          st_d = ST_LOW;
          if (rem_q == ONE) begin
            ctr_d = '0;
            rem_d = '0;
          end else begin
            ctr_d = low_w_q - ONE;
            rem_d = rem_q - ONE;
          end
        end else begin
          ctr_d = ctr_q - ONE;
        end
        ST_LOW: if (ctr_q == '0) begin
          if (rem_q == '0) begin
            st_d = ST_IDLE;
          end else begin
            st_d  = ST_HIGH;
            ctr_d = wid_w_q - ONE;
          end
        end else begin
          ctr_d = ctr_q - ONE;
        end
        default: st_d = ST_IDLE;
      endcase
      if (abort) st_d = ST_IDLE;
    end

    // Sequencer state; the pulse output is registered off the next state.
    always_ff @(posedge CLK160M) begin
      if (RESET) begin
        st_q    <= ST_IDLE;
        ctr_q   <= '0;
        rem_q   <= '0;
        wid_w_q <= '0;
        low_w_q <= '0;
        pls_q   <= 1'b0;
      end else begin
        st_q    <= st_d;
        ctr_q   <= ctr_d;
        rem_q   <= rem_d;
        wid_w_q <= wid_w_d;
        low_w_q <= low_w_d;
        pls_q   <= (st_d == ST_HIGH);
      end
    end
  end

endmodule

// File: tb/tb_ptmch_trg_multi.sv
// Scoreboard bench: frames are queued with their commit cycle, a predictor
// builds each cycle's expected outputs from per-channel pulse schedules, and a
// monitor compares them against the DUT.
module tb_ptmch_trg_multi;
  localparam int NCH = 3;
  localparam int CNT_W = 16;
  localparam int HP = 5;
  localparam int GAP = 8;

  logic clk = 1'b0, rst, cs, sck, mosi;
  logic [NCH-1:0] trg, busy;
  logic err;
  int cyc = 0;
  int n_chk = 0, n_err = 0;

  ptmch_trg_multi #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .CLK160M(clk), .RESET(rst), .SPI_CS(cs), .SPI_CLK(sck), .SPI_MOSI(mosi),
    .TRG_PLS(trg), .BUSY(busy), .FRM_ERR(err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [31:0] f; int nb; } frm_t;
  typedef struct { int t; logic [NCH-1:0] p; logic [NCH-1:0] b; logic e; } exp_t;
  frm_t pend[$];
  exp_t expq[$];

  // Reference model: config values plus one pulse schedule per channel.
  int m_dly[NCH], m_wid[NCH], m_per[NCH], m_cnt[NCH];
  bit r_vld[NCH];
  int r_fire[NCH], r_first[NCH], r_wid[NCH], r_sp[NCH], r_n[NCH], r_stop[NCH];
  bit err_at[int];

  function automatic void m_reset();
    for (int k = 0; k < NCH; k++) begin
      m_dly[k] = 0; m_wid[k] = 1; m_per[k] = 2; m_cnt[k] = 1; r_vld[k] = 0;
    end
    err_at.delete();
  endfunction

  function automatic bit m_busy(input int k, input int t);
    return r_vld[k] && t > r_fire[k] && t <= r_stop[k];
  endfunction

  function automatic bit m_pls(input int k, input int t);
    if (!m_busy(k, t) || t < r_first[k]) return 0;
    return ((t - r_first[k]) % r_sp[k]) < r_wid[k] && ((t - r_first[k]) / r_sp[k]) < r_n[k];
  endfunction

  function automatic void m_fire(input int k, input int c);
    if (m_wid[k] == 0) return;
    r_vld[k]   = 1;
    r_fire[k]  = c;
    r_first[k] = c + 2 + m_dly[k];
    r_wid[k]   = m_wid[k];
    r_sp[k]    = (m_per[k] > m_wid[k]) ? m_per[k] : m_wid[k] + 1;
    r_n[k]     = (m_cnt[k] == 0) ? 1 : m_cnt[k];
    r_stop[k]  = r_first[k] + (r_n[k] - 1) * r_sp[k] + r_wid[k];
  endfunction

  function automatic void m_commit(input frm_t fr);
    int cmd, ch, d, c;
    c = fr.c;
    cmd = int'(fr.f[31:28]); ch = int'(fr.f[27:24]); d = int'(fr.f[15:0]);
    if (fr.nb != 32) begin err_at[c+1] = 1; return; end
    if (cmd >= 1 && cmd <= 4) begin
      if (ch >= NCH) err_at[c+1] = 1;
      else if (cmd == 1) m_dly[ch] = d;
      else if (cmd == 2) m_wid[ch] = d;
      else if (cmd == 3) m_per[ch] = d;
      else m_cnt[ch] = d;
    end else if (cmd == 8) begin
      if (ch == 15) begin
        for (int k = 0; k < NCH; k++) if (!m_busy(k, c)) m_fire(k, c);
      end else if (ch >= NCH) err_at[c+1] = 1;
      else if (m_busy(ch, c)) err_at[c+1] = 1;
      else m_fire(ch, c);
    end else if (cmd == 15) begin
      if (ch != 15 && ch >= NCH) err_at[c+1] = 1;
      else for (int k = 0; k < NCH; k++)
        if ((ch == 15 || ch == k) && m_busy(k, c)) r_stop[k] = c;
    end else begin
      err_at[c+1] = 1;
    end
  endfunction

  // Predictor: one expected record per cycle, then apply frames committing now.
  initial begin
    logic r;
    exp_t e;
    m_reset();
    forever begin
      @(posedge clk);
      r = rst;
      #2;
      if (r) m_reset();
      e.t = cyc;
      for (int k = 0; k < NCH; k++) begin
        e.p[k] = m_pls(k, cyc);
        e.b[k] = m_busy(k, cyc);
      end
      e.e = err_at.exists(cyc);
      expq.push_back(e);
      while (pend.size() > 0 && pend[0].c == cyc) m_commit(pend.pop_front());
    end
  end

  // Monitor.
  initial forever begin
    exp_t e;
    @(negedge clk);
    n_chk++;
    if (expq.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty cyc=%0d got nothing, need one record", cyc);
    end else begin
      e = expq.pop_front();
      if ({err, busy, trg} !== {e.e, e.b, e.p}) begin
        n_err++;
        $display("FAIL outputs cyc=%0d got err=%b busy=%b trg=%b, exp err=%b busy=%b trg=%b",
                 e.t, err, busy, trg, e.e, e.b, e.p);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int cmd, input int ch, input int d, input int nb = 32);
    logic [31:0] f;
    frm_t fr;
    f = {4'(cmd), 4'(ch), 8'($urandom), 16'(d)};
    cs = 1'b0;
    for (int b = 0; b < nb; b++) begin
      mosi = (b < 32) ? f[31-b] : 1'($urandom);
      tick(HP); sck = 1'b1;
      tick(HP); sck = 1'b0;
    end
    tick(HP);
    cs = 1'b1;
    fr.c = cyc + 2; fr.f = f; fr.nb = nb;
    pend.push_back(fr);
    tick(GAP);
  endtask

  task automatic do_reset();
    rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(4);
  endtask

  initial begin
    int cmds[9] = '{1, 2, 3, 4, 8, 8, 15, 5, 0};
    int chs[5]  = '{0, 1, 2, 15, 7};
    rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    do_reset();
    // single delayed pulse on ch0
    send(1, 0, 3); send(2, 0, 4); send(4, 0, 1); send(8, 0, 0);
    tick(30);
    // three-pulse burst on ch1
    send(2, 1, 2); send(3, 1, 5); send(4, 1, 3); send(8, 1, 0);
    tick(40);
    // short and long frames are dropped
    send(2, 0, 9, 31); send(2, 0, 9, 33); send(8, 0, 0);
    tick(30);
    // long burst, width rewritten mid-burst, aborted, refired with new width
    send(4, 0, 100); send(3, 0, 30); send(8, 0, 0);
    send(2, 0, 7); send(15, 0, 0);
    send(4, 0, 2); send(8, 0, 0);
    tick(60);
    // broadcast FIRE with ch0 busy, then unknown cmd, then broadcast ABORT
    send(4, 0, 100); send(8, 0, 0); send(8, 15, 0); send(5, 0, 0);
    send(8, 0, 0); send(15, 15, 0);
    tick(20);
    // reset mid-frame
    cs = 1'b0;
    for (int b = 0; b < 10; b++) begin
      mosi = 1'($urandom); tick(HP); sck = 1'b1; tick(HP); sck = 1'b0;
    end
    do_reset();
    send(8, 0, 0);
    tick(20);
    // reset mid-pulse
    send(2, 1, 20); send(8, 1, 0);
    do_reset();
    send(8, 0, 0);
    tick(20);
    // randomized frames
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      send(cmds[$urandom_range(0, 8)], chs[$urandom_range(0, 4)], $urandom_range(0, 12),
           (r == 0) ? 31 : (r == 1) ? 33 : 32);
      tick($urandom_range(0, 30));
    end
    tick(300);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
